ddr_aw_issuer: RTL
==================

Name: ddr_aw_issuer

Overview:
- Downstream consumer of the write-address sync FIFO (32-bit entries, depth 512) on the DDR write path.
- Pops one burst start address at a time and drives it onto the AXI write-address channel of the DDR controller.
- Tracks outstanding bursts against write responses, enforces a maximum-outstanding limit, and flags error responses.

Parameters:
- ADDR_WIDTH, 32, width of FIFO entry and AXI awaddr.
- ID_WIDTH, 4, width of axi_awid.
- AXI_ID, 0, constant ID driven on axi_awid.
- BURST_LEN, 16, beats per burst; axi_awlen = BURST_LEN-1; legal 1..256.
- SIZE_LOG2, 5, log2 of bytes per beat (256-bit data bus); drives axi_awsize.
- MAX_OUTSTANDING, 8, maximum issued-but-unacknowledged bursts; legal 1..15.
- CNT_WIDTH, 4, width of outstanding counter; must satisfy 2^CNT_WIDTH > MAX_OUTSTANDING.

Ports:
- clk  in  1  single clock; the FIFO, this block and the AXI interface all run on it.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_rd_en  out  1  FIFO read enable, one-cycle pulse.
- fifo_rd_data  in  ADDR_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- axi_awaddr  out  ADDR_WIDTH  burst start address.
- axi_awlen  out  8  constant BURST_LEN-1.
- axi_awsize  out  3  constant SIZE_LOG2.
- axi_awburst  out  2  constant 2'b01 (INCR).
- axi_awid  out  ID_WIDTH  constant AXI_ID.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address accepted.
- axi_bvalid  in  1  write response valid.
- axi_bresp  in  2  write response code.
- axi_bready  out  1  write response ready; tied high after reset.
- outstanding  out  CNT_WIDTH  current count of unacknowledged bursts.
- resp_err  out  1  sticky error flag.
- err_clr  in  1  clears resp_err.
- busy  out  1  high when the FSM is not in IDLE or outstanding != 0.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; fifo_rd_en=0; axi_awvalid=0; axi_awaddr=0; axi_bready=0; outstanding=0; resp_err=0; busy=0. axi_bready goes to 1 on the first clock after release.
- FSM states IDLE, POP, LOAD, ADDR:
  - IDLE -> POP when !fifo_rd_empty && outstanding < MAX_OUTSTANDING. fifo_rd_en is a registered pulse, high for exactly the POP cycle.
  - POP -> LOAD unconditionally.
  - LOAD: capture fifo_rd_data into axi_awaddr with bits [SIZE_LOG2-1:0] forced to 0; -> ADDR. axi_awvalid rises entering ADDR.
  - ADDR: hold axi_awvalid and axi_awaddr stable until axi_awready. On the handshake cycle, axi_awvalid falls next cycle and the FSM returns to IDLE.
- Minimum issue interval is 4 cycles per burst. Never pop from an empty FIFO. Never pop while outstanding == MAX_OUTSTANDING.
- outstanding:
  - +1 on the AW handshake.
  - -1 on axi_bvalid && axi_bready.
  - Both in the same cycle: unchanged.
  - bvalid while outstanding == 0: counter held at 0 (no underflow) and resp_err set.
- resp_err: set on any accepted response with bresp != 2'b00. err_clr clears it; a set event in the same cycle as err_clr wins.
- The outstanding check uses the registered count, so a response arriving in the IDLE cycle takes effect the following cycle.
- Reset mid-burst: awvalid drops immediately. The popped address is lost; the upstream FIFO is reset together with this block.

Decomposition:
- Shared package ddr_axi_pkg holds the AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00 and state encoding constants.
- One sub-module, ddr_outstanding_cnt (saturating up/down counter with simultaneous-event handling and underflow flag), reused later by the AR issuer.

Test Plan:
- Reset values: hold rst_n=0 with FIFO non-empty -> fifo_rd_en=0, awvalid=0, outstanding=0, resp_err=0. After release, bready=1 next cycle; first fifo_rd_en one cycle later.
- Single issue: FIFO holds 0x0000_1234, awready=1 -> fifo_rd_en 1 cycle, awvalid 1 cycle with awaddr=0x0000_1220, awlen=8'd15, awsize=3'd5, awburst=2'b01; outstanding=1.
- Backpressure: awready held low 5 cycles -> awvalid and awaddr stable all 6 cycles; no second fifo_rd_en until handshake plus return to IDLE.
- Outstanding limit: MAX_OUTSTANDING=8, 10 entries, no bvalid -> exactly 8 AW handshakes, outstanding=8, FIFO keeps 2 entries. One bvalid OKAY -> outstanding 7, then ninth issue.
- Simultaneous events: AW handshake and bvalid in the same cycle at outstanding=3 -> outstanding stays 3. Stray bvalid at outstanding=0 -> stays 0, resp_err=1.
- Error flag: bresp=2'b10 -> resp_err=1 and stays set through later OKAY responses. err_clr pulse -> 0. err_clr coincident with SLVERR -> stays 1.

Source files
------------

// File: rtl/ddr_axi_pkg.sv
// rtl/ddr_axi_pkg.sv - shared AXI constants and issuer state encoding
package ddr_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_LOAD = 2'd2,
        ST_ADDR = 2'd3
    } aw_state_t;

endpackage

// File: rtl/ddr_outstanding_cnt.sv
// rtl/ddr_outstanding_cnt.sv - saturating up/down outstanding-burst counter
module ddr_outstanding_cnt #(
    parameter int CNT_WIDTH = 4,
    parameter int MAX_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 at_max,
    output logic                 underflow
);

    // A decrement with nothing outstanding is a protocol violation; the count holds at zero.
    assign underflow = dec && (count == '0);
    assign at_max    = (count >= CNT_WIDTH'(MAX_COUNT));

    // Simultaneous increment and decrement cancel; both directions saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (!at_max) begin
                count <= count + CNT_WIDTH'(1);
            end
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ddr_aw_issuer.sv
// rtl/ddr_aw_issuer.sv - pops burst addresses from the write FIFO and issues them on AXI AW
module ddr_aw_issuer
    import ddr_axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int BURST_LEN       = 16,
    parameter int SIZE_LOG2       = 5,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [ADDR_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic [ID_WIDTH-1:0]   axi_awid,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    input  logic                  axi_bvalid,
    input  logic [1:0]            axi_bresp,
    output logic                  axi_bready,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  resp_err,
    input  logic                  err_clr,
    output logic                  busy
);

    // Clears the sub-beat address bits so every burst starts on a bus-width boundary.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << SIZE_LOG2) - ADDR_WIDTH'(1));

    aw_state_t state;
    aw_state_t state_next;
    logic      aw_fire;
    logic      b_fire;
    logic      at_max;
    logic      underflow;

    assign axi_awlen   = 8'(BURST_LEN - 1);
    assign axi_awsize  = 3'(SIZE_LOG2);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_awid    = ID_WIDTH'(AXI_ID);

    assign aw_fire = axi_awvalid && axi_awready;
    assign b_fire  = axi_bvalid && axi_bready;
    assign busy    = (state != ST_IDLE) || (outstanding != '0);

    ddr_outstanding_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (aw_fire),
        .dec       (b_fire),
        .count     (outstanding),
        .at_max    (at_max),
        .underflow (underflow)
    );

    // Next-state logic; the first pop waits until bready is up, one cycle after reset release.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (axi_bready && !fifo_rd_empty && !at_max) state_next = ST_POP;
            ST_POP:  state_next = ST_LOAD;
            ST_LOAD: state_next = ST_ADDR;
            ST_ADDR: if (axi_awready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus registered rd_en/awvalid decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fifo_rd_en  <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_bready  <= 1'b0;
        end else begin
            state       <= state_next;
            fifo_rd_en  <= (state_next == ST_POP);
            axi_awvalid <= (state_next == ST_ADDR);
            axi_bready  <= 1'b1;
        end
    end

    // FIFO data is valid in LOAD; the address then holds until the next burst is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_awaddr <= '0;
        end else if (state == ST_LOAD) begin
            axi_awaddr <= fifo_rd_data & ADDR_MASK;
        end
    end

    // Sticky error: a set event beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err <= 1'b0;
        end else if ((b_fire && (axi_bresp != AXI_RESP_OKAY)) || underflow) begin
            resp_err <= 1'b1;
        end else if (err_clr) begin
            resp_err <= 1'b0;
        end
    end

endmodule
